// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU function sequencer: op encoding, FSM states and the
// op -> relay function-line lookup.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_INC = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHL = 3'd6,
    OP_CLR = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_CAPTURE
  } seq_state_e;

  // {f1,f2,f3} coil pattern, indexed by alu_op_e
  localparam logic [2:0] F_LINES_LUT [8] = '{
    3'b111, 3'b011, 3'b101, 3'b001,
    3'b110, 3'b010, 3'b100, 3'b000
  };

  function automatic logic [2:0] op_to_f_lines(input alu_op_e op);
    return F_LINES_LUT[op];
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Down-counter that holds off capture while the relay function lines settle.
// Loaded with SETTLE_CYCLES-1 at accept; expire is high in the cycle the count is zero.
module settle_timer #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic run,
  output logic expire
);

  localparam int CNT_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("settle_timer: SETTLE_CYCLES must be at least 1");
  end

  logic [CNT_W-1:0] count;

  assign expire = run && (count == '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (run && (count != '0)) begin
      count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_function_sequencer.sv
// Drives the relay ALU function lines for one decoded op, waits for the relays to
// settle, then captures the result into A or D and updates the Z/C/S flags.
module alu_function_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic              req_dest,
  output logic [2:0]        f_lines,
  output logic              alu_enable,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry,
  output logic [DATA_W-1:0] a_reg,
  output logic [DATA_W-1:0] d_reg,
  output logic              flag_z,
  output logic              flag_c,
  output logic              flag_s,
  output logic              done,
  output logic              busy
);

  seq_state_e        state;
  alu_op_e           op_q;
  logic              dest_q;
  logic              accept;
  logic              settle_expire;
  logic [DATA_W-1:0] cap_val;
  logic              cap_carry;

  assign accept    = (state == ST_IDLE) && req_valid && req_ready;
  assign busy      = ~req_ready;
  // CLR ignores whatever the unpowered-logic path presents on alu_result
  assign cap_val   = (op_q == OP_CLR) ? '0 : alu_result;
  assign cap_carry = ((op_q == OP_ADD) || (op_q == OP_INC)) ? alu_carry : 1'b0;

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (accept),
    .run    (state == ST_SETTLE),
    .expire (settle_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      op_q       <= OP_ADD;
      dest_q     <= 1'b0;
      a_reg      <= '0;
      d_reg      <= '0;
      flag_z     <= 1'b0;
      flag_c     <= 1'b0;
      flag_s     <= 1'b0;
      f_lines    <= 3'b000;
      alu_enable <= 1'b0;
      done       <= 1'b0;
      req_ready  <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            op_q       <= alu_op_e'(req_op);
            dest_q     <= req_dest;
            f_lines    <= op_to_f_lines(alu_op_e'(req_op));
            alu_enable <= 1'b1;
            req_ready  <= 1'b0;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_expire) begin
            done  <= 1'b1;
            state <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (dest_q) begin
            d_reg <= cap_val;
          end else begin
            a_reg <= cap_val;
          end
          flag_z     <= (cap_val == '0);
          flag_c     <= cap_carry;
          flag_s     <= cap_val[DATA_W-1];
          f_lines    <= 3'b000;
          alu_enable <= 1'b0;
          done       <= 1'b0;
          req_ready  <= 1'b1;
          state      <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_function_sequencer.sv
// Directed bench for alu_function_sequencer: table of single ops, back-to-back
// throughput, reset mid-op, and a SETTLE_CYCLES=1 instance.
module tb_alu_function_sequencer;

  typedef struct {
    logic [2:0] op;
    logic       dest;
    logic [7:0] res;
    logic       carry;
    logic [2:0] exp_f;
    logic [7:0] exp_a;
    logic [7:0] exp_d;
    logic       exp_z;
    logic       exp_c;
    logic       exp_s;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid, req_dest, alu_carry;
  logic [2:0] req_op;
  logic [7:0] alu_result;
  logic       req_ready, alu_enable, flag_z, flag_c, flag_s, done, busy;
  logic [2:0] f_lines;
  logic [7:0] a_reg, d_reg;

  logic       req_valid_1, req_dest_1, alu_carry_1;
  logic [2:0] req_op_1;
  logic [7:0] alu_result_1;
  logic       req_ready_1, alu_enable_1, flag_z_1, flag_c_1, flag_s_1, done_1, busy_1;
  logic [2:0] f_lines_1;
  logic [7:0] a_reg_1, d_reg_1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  vec_t vecs [10];
  vec_t ops5 [4];

  always #5 clk = ~clk;

  alu_function_sequencer #(.DATA_W(8), .SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_dest(req_dest), .f_lines(f_lines), .alu_enable(alu_enable),
    .alu_result(alu_result), .alu_carry(alu_carry), .a_reg(a_reg), .d_reg(d_reg),
    .flag_z(flag_z), .flag_c(flag_c), .flag_s(flag_s), .done(done), .busy(busy)
  );

  alu_function_sequencer #(.DATA_W(8), .SETTLE_CYCLES(1)) dut_fast (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_1), .req_ready(req_ready_1),
    .req_op(req_op_1), .req_dest(req_dest_1), .f_lines(f_lines_1), .alu_enable(alu_enable_1),
    .alu_result(alu_result_1), .alu_carry(alu_carry_1), .a_reg(a_reg_1), .d_reg(d_reg_1),
    .flag_z(flag_z_1), .flag_c(flag_c_1), .flag_s(flag_s_1), .done(done_1), .busy(busy_1)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
  endtask

  task automatic checkReset(input string pfx);
    checkOutput({pfx, "_a"}, a_reg, 8'h00);
    checkOutput({pfx, "_d"}, d_reg, 8'h00);
    checkOutput({pfx, "_z"}, flag_z, 1'b0);
    checkOutput({pfx, "_c"}, flag_c, 1'b0);
    checkOutput({pfx, "_s"}, flag_s, 1'b0);
    checkOutput({pfx, "_f"}, f_lines, 3'b000);
    checkOutput({pfx, "_en"}, alu_enable, 1'b0);
    checkOutput({pfx, "_ready"}, req_ready, 1'b1);
    checkOutput({pfx, "_busy"}, busy, 1'b0);
    checkOutput({pfx, "_done"}, done, 1'b0);
  endtask

  task automatic waitReady();
    int n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) checkOutput("ready_timeout", 32'd0, 32'd1);
  endtask

  // One op through the whole accept / settle / capture sequence
  task automatic applyStimulus(input vec_t v, input int idx);
    waitReady();
    req_valid  = 1'b1;
    req_op     = v.op;
    req_dest   = v.dest;
    alu_result = v.res;
    alu_carry  = v.carry;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_op    = ~v.op;
    req_dest  = ~v.dest;
    for (int k = 1; k <= 3; k++) begin
      checkOutput($sformatf("v%0d_c%0d_f", idx, k), f_lines, v.exp_f);
      checkOutput($sformatf("v%0d_c%0d_en", idx, k), alu_enable, 1'b1);
      checkOutput($sformatf("v%0d_c%0d_ready", idx, k), req_ready, 1'b0);
      checkOutput($sformatf("v%0d_c%0d_busy", idx, k), busy, 1'b1);
      checkOutput($sformatf("v%0d_c%0d_done", idx, k), done, (k == 3) ? 1'b1 : 1'b0);
      @(posedge clk); #1;
    end
    checkOutput($sformatf("v%0d_a", idx), a_reg, v.exp_a);
    checkOutput($sformatf("v%0d_d", idx), d_reg, v.exp_d);
    checkOutput($sformatf("v%0d_z", idx), flag_z, v.exp_z);
    checkOutput($sformatf("v%0d_c", idx), flag_c, v.exp_c);
    checkOutput($sformatf("v%0d_s", idx), flag_s, v.exp_s);
    checkOutput($sformatf("v%0d_done_end", idx), done, 1'b0);
    checkOutput($sformatf("v%0d_ready_end", idx), req_ready, 1'b1);
    checkOutput($sformatf("v%0d_en_end", idx), alu_enable, 1'b0);
    checkOutput($sformatf("v%0d_f_end", idx), f_lines, 3'b000);
  endtask

  initial begin
    int   acc_cyc [4];
    int   n, done_cnt, low_cnt, cyc, any_done;
    logic hs;

    //              op     dst  res    cy    f       a      d      z  c  s
    vecs[0] = '{3'd0, 1'b0, 8'h00, 1'b1, 3'b111, 8'h00, 8'h00, 1, 1, 0};
    vecs[1] = '{3'd7, 1'b1, 8'h5A, 1'b1, 3'b000, 8'h00, 8'h00, 1, 0, 0};
    vecs[2] = '{3'd2, 1'b0, 8'h80, 1'b1, 3'b101, 8'h80, 8'h00, 0, 0, 1};
    vecs[3] = '{3'd1, 1'b1, 8'h7F, 1'b0, 3'b011, 8'h80, 8'h7F, 0, 0, 0};
    vecs[4] = '{3'd3, 1'b0, 8'h3C, 1'b1, 3'b001, 8'h3C, 8'h7F, 0, 0, 0};
    vecs[5] = '{3'd4, 1'b1, 8'h00, 1'b1, 3'b110, 8'h3C, 8'h00, 1, 0, 0};
    vecs[6] = '{3'd5, 1'b0, 8'hC3, 1'b0, 3'b010, 8'hC3, 8'h00, 0, 0, 1};
    vecs[7] = '{3'd6, 1'b1, 8'hFE, 1'b1, 3'b100, 8'hC3, 8'hFE, 0, 0, 1};
    vecs[8] = '{3'd0, 1'b1, 8'hFF, 1'b0, 3'b111, 8'hC3, 8'hFF, 0, 0, 1};
    vecs[9] = '{3'd1, 1'b0, 8'h00, 1'b1, 3'b011, 8'h00, 8'hFF, 1, 1, 0};

    ops5[0] = '{3'd0, 1'b0, 8'h11, 1'b1, 3'b111, 8'h00, 8'h00, 0, 0, 0};
    ops5[1] = '{3'd4, 1'b1, 8'h22, 1'b0, 3'b110, 8'h00, 8'h00, 0, 0, 0};
    ops5[2] = '{3'd6, 1'b0, 8'h44, 1'b1, 3'b100, 8'h00, 8'h00, 0, 0, 0};
    ops5[3] = '{3'd7, 1'b1, 8'h99, 1'b1, 3'b000, 8'h00, 8'h00, 0, 0, 0};

    rst_n = 1'b0;
    req_valid = 1'b0; req_op = 3'd0; req_dest = 1'b0; alu_result = 8'h00; alu_carry = 1'b0;
    req_valid_1 = 1'b0; req_op_1 = 3'd0; req_dest_1 = 1'b0; alu_result_1 = 8'h00; alu_carry_1 = 1'b0;
    @(posedge clk); #1;
    checkReset("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] single-op vector table");
    for (int i = 0; i < 10; i++) applyStimulus(vecs[i], i);

    $display("[TB] back-to-back ops with req_valid held high");
    n = 0; done_cnt = 0; low_cnt = 0; cyc = 0;
    req_valid  = 1'b1;
    req_op     = ops5[0].op;
    req_dest   = ops5[0].dest;
    while ((n < 4 || done_cnt < 4) && cyc < 60) begin
      hs = req_valid && req_ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) begin
        acc_cyc[n] = cyc;
        alu_result = ops5[n].res;
        alu_carry  = ops5[n].carry;
        n++;
        if (n == 4) req_valid = 1'b0;
      end
      if (done) done_cnt++;
      if (!req_ready) low_cnt++;
      if (req_ready) begin
        if (n < 4) begin
          req_op   = ops5[n].op;
          req_dest = ops5[n].dest;
        end
      end else begin
        req_op   = 3'($urandom);
        req_dest = 1'($urandom);
      end
    end
    checkOutput("b2b_accepts", n, 4);
    checkOutput("b2b_dones", done_cnt, 4);
    checkOutput("b2b_ready_low", low_cnt, 12);
    for (int i = 1; i < 4; i++)
      if (i < n) checkOutput($sformatf("b2b_spacing%0d", i), acc_cyc[i] - acc_cyc[i-1], 4);
    @(posedge clk); #1;
    checkOutput("b2b_a", a_reg, 8'h44);
    checkOutput("b2b_d", d_reg, 8'h00);
    checkOutput("b2b_z", flag_z, 1'b1);
    checkOutput("b2b_c", flag_c, 1'b0);
    checkOutput("b2b_s", flag_s, 1'b0);

    $display("[TB] reset during settle");
    waitReady();
    req_valid = 1'b1; req_op = 3'd0; req_dest = 1'b0; alu_result = 8'h77; alu_carry = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("rst_mid_en_before", alu_enable, 1'b1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    checkReset("rst_mid");
    rst_n = 1'b1;
    any_done = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || alu_enable !== 1'b0) any_done = 1;
    end
    checkOutput("rst_mid_no_done", any_done, 0);
    checkOutput("rst_mid_a_after", a_reg, 8'h00);

    $display("[TB] SETTLE_CYCLES=1 instance");
    req_valid_1 = 1'b1; req_op_1 = 3'd1; req_dest_1 = 1'b1; alu_result_1 = 8'h81; alu_carry_1 = 1'b1;
    @(posedge clk); #1;
    req_valid_1 = 1'b0;
    checkOutput("fast_t1_done", done_1, 1'b0);
    checkOutput("fast_t1_f", f_lines_1, 3'b011);
    checkOutput("fast_t1_en", alu_enable_1, 1'b1);
    checkOutput("fast_t1_ready", req_ready_1, 1'b0);
    @(posedge clk); #1;
    checkOutput("fast_t2_done", done_1, 1'b1);
    checkOutput("fast_t2_f", f_lines_1, 3'b011);
    @(posedge clk); #1;
    checkOutput("fast_d", d_reg_1, 8'h81);
    checkOutput("fast_a", a_reg_1, 8'h00);
    checkOutput("fast_z", flag_z_1, 1'b0);
    checkOutput("fast_c", flag_c_1, 1'b1);
    checkOutput("fast_s", flag_s_1, 1'b1);
    checkOutput("fast_done_end", done_1, 1'b0);
    checkOutput("fast_ready_end", req_ready_1, 1'b1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
